// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the pixel frame-buffer writer:
//   - fb_state_e       : writer FSM states (idle / filling a frame / frame done)
//   - field widths of the pixel stream and the skid-buffer payload
//   - rgb888_to_565()  : truncating RGB888 -> RGB565 conversion
// -----------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } fb_state_e;

    localparam int unsigned PIX_W    = 24;
    localparam int unsigned HCNT_W   = 11;
    localparam int unsigned VCNT_W   = 10;
    localparam int unsigned SKID_W   = PIX_W + HCNT_W + VCNT_W;  // 45-bit payload
    localparam int unsigned RGB565_W = 16;

    // Keeps the top bits of each channel; low bits are simply dropped.
    function automatic logic [RGB565_W-1:0] rgb888_to_565(input logic [PIX_W-1:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// -----------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry FIFO that decouples the pixel stream handshake from the memory
// write port. Full/empty come straight from a registered occupancy count, so
// the upstream ready never depends combinationally on the pop side.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset (empties the buffer)
//   i_push   : write i_data (ignored when full)
//   i_data   : payload to store
//   i_pop    : discard head entry (ignored when empty)
//   o_data   : head entry
//   o_empty  : no entries held
//   o_full   : both entries held
// -----------------------------------------------------------------------------
module axis_skid_buffer
    import fb_pkg::*;
#(
    parameter int unsigned DATA_W = SKID_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_empty,
    output logic              o_full
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic w_push;
    logic w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = i_pop  && (r_count != 2'd0);
    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_fb_writer.sv
// -----------------------------------------------------------------------------
// pixel_fb_writer
// Writes one frame of an RGB888 pixel stream into a double-buffered RGB565
// frame buffer. A frame fill is armed by frame_start, completes after
// H_RES*V_RES in-range pixels have been written, and the filled bank is handed
// to the display side on swap_ack.
//
// Ports
//   aclk, aresetn       : clock (rising edge) / asynchronous active-low reset
//   pixel_axis_tdata    : {R,G,B} 8 bits each
//   pixel_axis_tvalid   : pixel valid
//   pixel_axis_tready   : writer can accept (FILL and skid buffer not full)
//   hcount_in/vcount_in : pixel column/row, qualified by tvalid
//   frame_start         : pulse, arms a fill from IDLE
//   swap_ack            : pulse, display took the completed bank (DONE only)
//   wr_stall            : memory write port unavailable this cycle
//   fb_we/fb_addr/fb_wdata : registered write port, fb_addr = {bank, word}
//   display_bank        : bank the display reads; writes go to the other one
//   frame_done          : pulse, cycle after the final write of a frame
//   busy                : high while filling
// -----------------------------------------------------------------------------
module pixel_fb_writer
    import fb_pkg::*;
#(
    parameter int unsigned H_RES  = 320,
    parameter int unsigned V_RES  = 180,
    parameter int unsigned ADDR_W = 17
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [PIX_W-1:0]    pixel_axis_tdata,
    input  logic                pixel_axis_tvalid,
    output logic                pixel_axis_tready,
    input  logic [HCNT_W-1:0]   hcount_in,
    input  logic [VCNT_W-1:0]   vcount_in,
    input  logic                frame_start,
    input  logic                swap_ack,
    input  logic                wr_stall,
    output logic                fb_we,
    output logic [ADDR_W:0]     fb_addr,
    output logic [RGB565_W-1:0] fb_wdata,
    output logic                display_bank,
    output logic                frame_done,
    output logic                busy
);

    localparam int unsigned TOTAL = H_RES * V_RES;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    fb_state_e           r_state;
    fb_state_e           w_state_next;
    logic [CNT_W-1:0]    r_pix_cnt;
    logic                r_display_bank;
    logic                r_we;
    logic [ADDR_W:0]     r_addr;
    logic [RGB565_W-1:0] r_wdata;
    logic                r_final_wr;
    logic                r_frame_done;

    logic                w_skid_empty;
    logic                w_skid_full;
    logic                w_push;
    logic                w_pop;
    logic [SKID_W-1:0]   w_skid_in;
    logic [SKID_W-1:0]   w_skid_out;
    logic [PIX_W-1:0]    w_pix;
    logic [HCNT_W-1:0]   w_h;
    logic [VCNT_W-1:0]   w_v;
    logic [ADDR_W-1:0]   w_word;
    logic                w_in_range;
    logic                w_issue;
    logic                w_last_issue;
    logic                w_start;

    // -------------------------------------------------------------------------
    // Skid buffer between the stream and the write port
    // -------------------------------------------------------------------------
    assign w_skid_in         = {pixel_axis_tdata, hcount_in, vcount_in};
    assign pixel_axis_tready = (r_state == StFill) && !w_skid_full;
    assign w_push            = pixel_axis_tvalid && pixel_axis_tready;
    // Popping continues in every state so leftovers drain and are discarded.
    assign w_pop             = !w_skid_empty && !wr_stall;

    axis_skid_buffer #(
        .DATA_W (SKID_W)
    ) u_skid (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_push  (w_push),
        .i_data  (w_skid_in),
        .i_pop   (w_pop),
        .o_data  (w_skid_out),
        .o_empty (w_skid_empty),
        .o_full  (w_skid_full)
    );

    assign {w_pix, w_h, w_v} = w_skid_out;

    // 32-bit arithmetic; any in-range pixel fits in ADDR_W bits by construction.
    assign w_word       = ADDR_W'(32'(w_v) * H_RES + 32'(w_h));
    assign w_in_range   = (32'(w_h) < H_RES) && (32'(w_v) < V_RES);
    assign w_issue      = w_pop && w_in_range && (r_state == StFill);
    assign w_last_issue = w_issue && (r_pix_cnt == CNT_W'(TOTAL - 1));
    assign w_start      = (r_state == StIdle) && frame_start;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (frame_start)  w_state_next = StFill;
            StFill: if (w_last_issue) w_state_next = StDone;
            // frame_start together with swap_ack only swaps; it does not re-arm.
            StDone: if (swap_ack)     w_state_next = StIdle;
            default:                  w_state_next = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // Pixel counter, bank select, write port, completion pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pix_cnt      <= '0;
            r_display_bank <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_final_wr     <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            if (w_start) begin
                r_pix_cnt <= '0;
            end else if (w_issue) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end

            if ((r_state == StDone) && swap_ack) begin
                r_display_bank <= ~r_display_bank;
            end

            r_we <= w_issue;
            if (w_issue) begin
                r_addr  <= {~r_display_bank, w_word};
                r_wdata <= rgb888_to_565(w_pix);
            end

            // r_final_wr lines up with the final fb_we; frame_done follows it.
            r_final_wr   <= w_last_issue;
            r_frame_done <= r_final_wr;
        end
    end

    assign fb_we        = r_we;
    assign fb_addr      = r_addr;
    assign fb_wdata     = r_wdata;
    assign display_bank = r_display_bank;
    assign frame_done   = r_frame_done;
    assign busy         = (r_state == StFill);

endmodule

// File: tb/tb_pixel_fb_writer.sv
module tb_pixel_fb_writer;

    localparam int unsigned H_RES  = 320;
    localparam int unsigned V_RES  = 180;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned TOTAL  = H_RES * V_RES;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [23:0]       pixel_axis_tdata = '0;
    logic              pixel_axis_tvalid = 1'b0;
    logic              pixel_axis_tready;
    logic [10:0]       hcount_in = '0;
    logic [9:0]        vcount_in = '0;
    logic              frame_start = 1'b0;
    logic              swap_ack = 1'b0;
    logic              wr_stall = 1'b0;
    logic              fb_we;
    logic [ADDR_W:0]   fb_addr;
    logic [15:0]       fb_wdata;
    logic              display_bank;
    logic              frame_done;
    logic              busy;

    always #5 aclk = ~aclk;

    pixel_fb_writer #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .pixel_axis_tdata  (pixel_axis_tdata),
        .pixel_axis_tvalid (pixel_axis_tvalid),
        .pixel_axis_tready (pixel_axis_tready),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .frame_start       (frame_start),
        .swap_ack          (swap_ack),
        .wr_stall          (wr_stall),
        .fb_we             (fb_we),
        .fb_addr           (fb_addr),
        .fb_wdata          (fb_wdata),
        .display_bank      (display_bank),
        .frame_done        (frame_done),
        .busy              (busy)
    );

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic [23:0] rgb;
    } pix_t;

    pix_t            send_q[$];
    logic [ADDR_W:0] exp_addr_q[$];
    logic [15:0]     exp_data_q[$];

    int              checks = 0;
    int              fails = 0;
    int              n_wr = 0;
    int              cyc_no = 0;
    int              hs_cyc = 0;
    int              wr_cyc = 0;
    logic            exp_bank = 1'b0;
    logic            prev_final = 1'b0;
    logic            fd_seen = 1'b0;
    logic            last_hs = 1'b0;
    logic            last_tready = 1'b0;
    logic [ADDR_W:0] last_addr = '0;
    logic [15:0]     last_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference colour conversion by plain integer arithmetic.
    function automatic logic [15:0] to565(input logic [23:0] c);
        int unsigned r;
        int unsigned g;
        int unsigned b;
        r = 32'(c[23:16]);
        g = 32'(c[15:8]);
        b = 32'(c[7:0]);
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    task automatic add_pix(input int unsigned h, input int unsigned v, input logic [23:0] rgb);
        pix_t p;
        p.h   = 11'(h);
        p.v   = 10'(v);
        p.rgb = rgb;
        send_q.push_back(p);
    endtask

    task automatic add_random(input int n);
        for (int i = 0; i < n; i++) begin
            add_pix($urandom_range(0, 329), $urandom_range(0, 189), 24'($urandom));
        end
    endtask

    // One clock cycle: drive inputs, model the handshake, then check outputs.
    task automatic cyc(input logic fs, input logic sa, input logic st);
        pix_t p;
        p           = '0;
        frame_start = fs;
        swap_ack    = sa;
        wr_stall    = st;
        if (send_q.size() > 0) begin
            p                 = send_q[0];
            pixel_axis_tvalid = 1'b1;
            pixel_axis_tdata  = p.rgb;
            hcount_in         = p.h;
            vcount_in         = p.v;
        end else begin
            pixel_axis_tvalid = 1'b0;
        end
        last_tready = pixel_axis_tready;
        last_hs     = pixel_axis_tvalid && pixel_axis_tready;
        if (last_hs) begin
            void'(send_q.pop_front());
            hs_cyc = cyc_no + 1;
            if (32'(p.h) < H_RES && 32'(p.v) < V_RES) begin
                exp_addr_q.push_back({~exp_bank, ADDR_W'(32'(p.v) * H_RES + 32'(p.h))});
                exp_data_q.push_back(to565(p.rgb));
            end
        end
        @(posedge aclk);
        #1;
        cyc_no++;
        frame_start = 1'b0;
        swap_ack    = 1'b0;
        chk("frame_done", 32'(frame_done), 32'(prev_final));
        if (frame_done === 1'b1) fd_seen = 1'b1;
        prev_final = 1'b0;
        if (fb_we === 1'b1) begin
            n_wr++;
            wr_cyc    = cyc_no;
            last_addr = fb_addr;
            last_data = fb_wdata;
            if (exp_addr_q.size() == 0) begin
                chk("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            end else begin
                chk("fb_addr", 32'(fb_addr), 32'(exp_addr_q.pop_front()));
                chk("fb_wdata", 32'(fb_wdata), 32'(exp_data_q.pop_front()));
            end
            if (n_wr == TOTAL) begin
                chk("last_fb_addr", 32'(fb_addr), 32'({1'b1, 17'd57599}));
                prev_final = 1'b1;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tready"}, 32'(pixel_axis_tready), 32'd0);
        chk({tag, "_fb_we"}, 32'(fb_we), 32'd0);
        chk({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
        chk({tag, "_fb_wdata"}, 32'(fb_wdata), 32'd0);
        chk({tag, "_display_bank"}, 32'(display_bank), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int acc;
        int guard;

        // Reset values while reset is held.
        #2;
        chk_reset_outputs("por");
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // IDLE: no acceptance even with valid data; swap_ack ignored.
        add_pix(5, 2, 24'hFF8040);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("tready_idle", 32'(last_tready), 32'd0);
        chk("swap_ignored_idle", 32'(display_bank), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);

        // Arm frame; directed pixel conversion, address and latency.
        cyc(1'b1, 1'b0, 1'b0);
        chk("busy_fill", 32'(busy), 32'd1);
        guard = 0;
        while (n_wr == 0 && guard < 8) begin
            cyc(1'b0, 1'b0, 1'b0);
            guard++;
        end
        chk("directed_written", 32'(n_wr), 32'd1);
        chk("directed_wdata", 32'(last_data), 32'hFC08);
        chk("directed_addr", 32'(last_addr), 32'({1'b1, 17'd645}));
        chk("hs_to_we_latency", 32'(wr_cyc - hs_cyc), 32'd1);

        // Stream with out-of-range pixels, then a 3-cycle write stall.
        add_random(40);
        add_pix(320, 0, 24'h123456);
        add_pix(0, 180, 24'h654321);
        add_pix(2047, 1023, 24'hABCDEF);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            acc += int'(last_hs);
        end
        chk("stall_accepts_le2", 32'(acc <= 2), 32'd1);
        chk("tready_low_in_stall", 32'(last_tready), 32'd0);

        // Random stalls until at least 100 writes.
        add_random(150);
        guard = 0;
        while (n_wr < 100 && guard < 1000) begin
            cyc(1'b0, 1'b0, ($urandom_range(0, 7) == 0));
            guard++;
        end
        chk("writes_before_reset", 32'(n_wr >= 100), 32'd1);

        // Asynchronous reset mid-frame: outputs clear without a clock edge.
        #2;
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        send_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        prev_final = 1'b0;
        n_wr = 0;
        exp_bank = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // No writes after reset until the next frame_start.
        add_random(3);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("no_write_after_reset", 32'(n_wr), 32'd0);
        chk("busy_after_reset", 32'(busy), 32'd0);
        send_q.delete();

        // Full raster frame, tvalid constant, a few out-of-range pixels mixed in.
        for (int v = 0; v < int'(V_RES); v++) begin
            for (int h = 0; h < int'(H_RES); h++) begin
                add_pix(h, v, 24'($urandom));
                if ((v * int'(H_RES) + h) % 9000 == 4500) begin
                    if (v % 2 == 0) add_pix(H_RES, v, 24'($urandom));
                    else            add_pix(h, V_RES, 24'($urandom));
                end
            end
        end
        fd_seen = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        guard = 0;
        // frame_start and swap_ack during FILL must be ignored.
        while (fd_seen == 1'b0 && guard < 60000) begin
            cyc(1'b0 | (guard == 20000), 1'b0 | (guard == 30000), 1'b0);
            guard++;
        end
        chk("frame_done_seen", 32'(fd_seen), 32'd1);
        chk("frame_writes", 32'(n_wr), 32'(TOTAL));
        chk("frame_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        chk("bank_kept_in_fill", 32'(display_bank), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
        chk("tready_done", 32'(pixel_axis_tready), 32'd0);

        // DONE: frame_start with swap_ack swaps only.
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("bank_swapped", 32'(display_bank), 32'd1);
        exp_bank = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("stay_out_of_fill", 32'(busy), 32'd0);

        // Next frame writes into bank 0.
        n_wr = 0;
        for (int i = 0; i < 20; i++) add_pix($urandom_range(0, 319), $urandom_range(0, 179), 24'($urandom));
        cyc(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (n_wr < 20 && guard < 200) begin
            cyc(1'b0, 1'b0, ($urandom_range(0, 3) == 0));
            guard++;
        end
        chk("second_frame_writes", 32'(n_wr), 32'd20);
        chk("second_frame_bank_msb", 32'(last_addr[ADDR_W]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 SHALL have parameter H_RES, default 320, active pixels per line.
REQ-002 SHALL have parameter V_RES, default 180, active lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, per-bank word address width; 2^ADDR_W >= H_RES*V_RES.
REQ-004 SHALL have port aclk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pixel_axis_tdata, input, 24, {R[23:16],G[15:8],B[7:0]}.
REQ-007 SHALL have port pixel_axis_tvalid, input, 1, pixel valid.
REQ-008 SHALL have port pixel_axis_tready, output, 1, pixel accepted when tvalid&&tready.
REQ-009 SHALL have port hcount_in, input, 11, pixel column, qualified by pixel_axis_tvalid.
REQ-010 SHALL have port vcount_in, input, 10, pixel row, qualified by pixel_axis_tvalid.
REQ-011 SHALL have port frame_start, input, 1, one-cycle pulse arming a frame fill.
REQ-012 SHALL have port swap_ack, input, 1, one-cycle pulse from display side; completed bank handed over.
REQ-013 SHALL have port wr_stall, input, 1, memory write port unavailable this cycle.
REQ-014 SHALL have port fb_we, output, 1, write strobe.
REQ-015 SHALL have port fb_addr, output, ADDR_W+1, {bank, word address}.
REQ-016 SHALL have port fb_wdata, output, 16, RGB565.
REQ-017 SHALL have port display_bank, output, 1, bank the display reads.
REQ-018 SHALL have port frame_done, output, 1, one-cycle pulse when fill completes.
REQ-019 SHALL have port busy, output, 1, high in FILL.

Function
REQ-020 SHALL implement states IDLE, FILL, DONE; IDLE->FILL on frame_start; FILL->DONE when pixel count reaches H_RES*V_RES; DONE->IDLE on swap_ack.
REQ-021 SHALL drive pixel_axis_tready high only in FILL while the 2-entry skid buffer is not full; never combinationally from wr_stall.
REQ-022 SHALL capture {pixel, hcount_in, vcount_in} into the skid buffer on each handshake.
REQ-023 SHALL pop the skid head when not empty and wr_stall low, registering fb_we=1 the next cycle: one-cycle latency from handshake to fb_we with no stall.
REQ-024 SHALL compute word address = vcount*H_RES + hcount, exact width, no truncation, registered with the pop.
REQ-025 SHALL output fb_addr MSB = ~display_bank (write bank).
REQ-026 SHALL convert to RGB565: {R[7:3],G[7:2],B[7:3]}, truncating.
REQ-027 SHALL drop popped pixels with hcount>=H_RES or vcount>=V_RES (fb_we=0, not counted).
REQ-028 SHALL increment the pixel counter only on issued writes; frame_done pulses the cycle after the final write.
REQ-029 SHALL toggle display_bank on swap_ack in DONE; swap_ack elsewhere ignored.
REQ-030 SHALL ignore frame_start outside IDLE; frame_start and swap_ack together in DONE: swap only, stay out of FILL until next frame_start.
REQ-031 SHALL keep draining buffered pixels after the count is reached; drained extras are discarded.

Reset
REQ-032 SHALL on aresetn low immediately force: state IDLE, skid empty, counter 0, tready 0, fb_we 0, fb_addr 0, fb_wdata 0, display_bank 0, frame_done 0, busy 0.
REQ-033 SHALL on reset mid-FILL discard partial frame; no further writes until next frame_start.

Structure
REQ-034 SHALL place state enum and RGB565 conversion function in shared package fb_pkg.
REQ-035 SHALL implement skid buffer as sub-module axis_skid_buffer (2 entries, 45-bit payload).

Verification
REQ-036 Full frame, no stall, tvalid constant -> 57600 writes, last fb_addr {1,57599}, frame_done one cycle after last fb_we.
REQ-037 Pixel 24'hFF8040 at (h=5,v=2) -> fb_wdata 16'hFC08, fb_addr {1,645}.
REQ-038 wr_stall high 3 cycles mid-stream -> tready low within 2 accepts, no pixel lost or duplicated, order preserved.
REQ-039 Pixel at h=320 or v=180 -> no fb_we, counter unchanged.
REQ-040 DONE, swap_ack -> display_bank 0->1; next frame writes fb_addr MSB 0.
REQ-041 aresetn low after 100 writes -> outputs at reset values same cycle, frame_start -> counter restarts at 0.
